// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter for the async FIFO write port
// Optional stall counter enabled by defining FIFO_ARB_STALL_CNT_EN.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                          i_write_clk,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic [NUM_REQ-1:0]            o_grant,
    input  logic                          i_write_full,
    output logic                          o_wr_en,
    output logic [DATA_WIDTH-1:0]         o_wr_data,
    output logic [15:0]                   o_stall_count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [IW-1:0]       r_gidx;
    logic [IW-1:0]       r_rr_ptr;
    logic [3:0]          r_beat_cnt;

    logic [NUM_REQ-1:0]    w_ack;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_granted_req;
    logic                  w_release;
    logic [IW-1:0]         w_next_ptr;
    logic [IW-1:0]         w_arb_ptr;
    logic [IW-1:0]         w_pick_idx;

    // First asserted request at or after ptr, wrapping past NUM_REQ-1.
    function automatic logic [IW-1:0] f_pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] ptr);
        logic [IW-1:0] sel;
        logic          found;
        int            j;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && r[IW'(j)]) begin
                sel   = IW'(j);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_ack         = r_grant & i_req & {NUM_REQ{~i_write_full}};
    assign w_wr_en       = |w_ack;
    assign w_granted_req = i_req[r_gidx];
    assign w_release     = ~w_granted_req | (w_wr_en & (r_beat_cnt == 4'(BURST_MAX - 1)));
    assign w_next_ptr    = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + IW'(1);
    // A releasing grant re-arbitrates from the advanced pointer so the holder ranks last.
    assign w_arb_ptr     = (r_state == S_BUSY) ? w_next_ptr : r_rr_ptr;
    assign w_pick_idx    = f_pick(i_req, w_arb_ptr);

    always_comb begin
        w_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_ack[i]) w_wr_data = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge i_write_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        r_state    <= S_BUSY;
                        r_gidx     <= w_pick_idx;
                        r_grant    <= NUM_REQ'(1) << w_pick_idx;
                        r_beat_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    if (w_release) begin
                        r_rr_ptr   <= w_next_ptr;
                        r_beat_cnt <= '0;
                        if (|i_req) begin
                            r_gidx  <= w_pick_idx;
                            r_grant <= NUM_REQ'(1) << w_pick_idx;
                        end else begin
                            r_state <= S_IDLE;
                            r_grant <= '0;
                        end
                    end else if (w_wr_en) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge i_write_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_count <= '0;
        end else if (r_state == S_BUSY && i_write_full && w_granted_req && r_stall_count != 16'hFFFF) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign o_stall_count = r_stall_count;
`else
    assign o_stall_count = 16'h0000;
`endif

    assign o_ack     = w_ack;
    assign o_grant   = r_grant;
    assign o_wr_en   = w_wr_en;
    assign o_wr_data = w_wr_data;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - vector table, reset corner and randomized model check
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            full = 1'b0;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic [15:0]     stall;

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .i_write_clk  (clk),
        .i_reset      (rst),
        .i_req        (req),
        .i_req_data   (req_data),
        .o_ack        (ack),
        .o_grant      (grant),
        .i_write_full (full),
        .o_wr_en      (wr_en),
        .o_wr_data    (wr_data),
        .o_stall_count(stall)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [N-1:0]  req;
        logic          full;
        logic [N-1:0]  grant;
        logic          wr;
        logic [DW-1:0] data;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] d[N];

    // Reference model state: busy flag, granted index, beats in burst, pointer, stalls
    bit m_busy;
    int m_g;
    int m_beats;
    int m_ptr;
    int m_stall;

    function automatic void add(logic [N-1:0] r, logic f, logic [N-1:0] g, logic w, logic [DW-1:0] dat);
        vec_t v;
        v.req = r; v.full = f; v.grant = g; v.wr = w; v.data = dat;
        tbl.push_back(v);
    endfunction

    task automatic check(string name, logic [N-1:0] eg, logic [N-1:0] eack, logic ew, logic [DW-1:0] ed);
        vectors++;
        if (grant !== eg || ack !== eack || wr_en !== ew || wr_data !== ed) begin
            miscompares++;
            $display("FAIL %s: got grant=%b ack=%b wr_en=%b wr_data=%h, expected grant=%b ack=%b wr_en=%b wr_data=%h",
                     name, grant, ack, wr_en, wr_data, eg, eack, ew, ed);
        end
    endtask

    task automatic check_stall(string name, logic [15:0] exp_v);
        vectors++;
        if (stall !== exp_v) begin
            miscompares++;
            $display("FAIL %s: stall_count got %0d expected %0d", name, stall, exp_v);
        end
    endtask

    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_g = 0; m_beats = 0; m_ptr = 0; m_stall = 0;
    endfunction

    // Advance the model across one clock edge given the inputs held during the cycle.
    function automatic void model_step(logic [N-1:0] r, logic f);
        bit acked;
        if (!m_busy) begin
            if (r != 0) begin
                m_busy = 1; m_g = pick(r, m_ptr); m_beats = 0;
            end
            return;
        end
        if (f && r[m_g] && m_stall < 65535) m_stall++;
        acked = r[m_g] && !f;
        if (acked) m_beats++;
        if (!r[m_g] || (acked && m_beats == BM)) begin
            m_ptr = (m_g + 1) % N;
            m_beats = 0;
            if (r != 0) m_g = pick(r, m_ptr);
            else m_busy = 0;
        end
    endfunction

    initial begin
        logic [N-1:0]  eg;
        logic [N-1:0]  ea;
        logic [DW-1:0] ed;
        logic [15:0]   exp_stall;
        logic          f;

        d[0] = 8'h10; d[1] = 8'h21; d[2] = 8'hA5; d[3] = 8'h3C;
        req_data = {d[3], d[2], d[1], d[0]};

        add(4'b0000, 0, 4'b0000, 0, 8'h00);
        add(4'b0100, 0, 4'b0000, 0, 8'h00);
        repeat (3) add(4'b0100, 0, 4'b0100, 1, d[2]);
        add(4'b0000, 0, 4'b0100, 0, 8'h00);
        add(4'b0000, 0, 4'b0000, 0, 8'h00);
        add(4'b1111, 0, 4'b0000, 0, 8'h00);
        foreach (d[k]) begin
            int idx;
            idx = (k + 3) % N;
            repeat (BM) add(4'b1111, 0, 4'(1 << idx), 1, d[idx]);
        end
        add(4'b1111, 0, 4'b1000, 1, d[3]);
        repeat (3) add(4'b1111, 1, 4'b1000, 0, 8'h00);
        repeat (3) add(4'b1111, 0, 4'b1000, 1, d[3]);
        add(4'b0000, 0, 4'b0001, 0, 8'h00);
        add(4'b0000, 0, 4'b0000, 0, 8'h00);

        #7 rst = 1'b0;
        @(negedge clk);
        check("reset", 4'b0000, 4'b0000, 0, 8'h00);
        check_stall("reset_stall", 16'h0000);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            req  = tbl[i].req;
            full = tbl[i].full;
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].grant, tbl[i].wr ? tbl[i].grant : 4'b0000, tbl[i].wr, tbl[i].data);
            @(posedge clk); #1;
        end
`ifdef FIFO_ARB_STALL_CNT_EN
        exp_stall = 16'd3;
`else
        exp_stall = 16'd0;
`endif
        check_stall("backpressure_stall", exp_stall);

        req = 4'b0010;
        @(negedge clk);
        check("rst_seq_idle", 4'b0000, 4'b0000, 0, 8'h00);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_seq_beat1", 4'b0010, 4'b0010, 1, d[1]);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_seq_beat2", 4'b0010, 4'b0010, 1, d[1]);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_seq_async", 4'b0000, 4'b0000, 0, 8'h00);
        check_stall("rst_seq_stall", 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0011;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_seq_ptr0", 4'b0001, 4'b0001, 1, d[0]);

        req = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            full     = ($urandom_range(0, 3) == 0);
            req_data = $urandom;
            @(negedge clk);
            eg = m_busy ? 4'(1 << m_g) : 4'b0000;
            f  = m_busy && req[m_g] && !full;
            ea = f ? eg : 4'b0000;
            ed = f ? req_data[m_g*DW +: DW] : 8'h00;
            check($sformatf("rand%0d", c), eg, ea, f, ed);
            model_step(req, full);
            @(posedge clk); #1;
        end
`ifdef FIFO_ARB_STALL_CNT_EN
        exp_stall = 16'(m_stall);
`else
        exp_stall = 16'd0;
`endif
        check_stall("rand_stall", exp_stall);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
